// File: rtl/xc_malu_pkg.sv
// Shared constants, state encoding and sign helper for the MALU divide sequencer.
package xc_malu_pkg;

  localparam int XLEN = 32;
  localparam int CW   = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // 0x80000000 maps to itself and is then treated as an unsigned magnitude.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? -x : x;
  endfunction

endpackage

// File: rtl/xc_malu_div_step.sv
// One restoring-division iteration: trial subtract of the shifted divisor and quotient bit set.
module xc_malu_div_step
  import xc_malu_pkg::*;
(
  input  logic [CW-1:0]     count,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   arg_0,
  input  logic [XLEN-1:0]   arg_1,
  output logic [2*XLEN-1:0] n_acc,
  output logic [XLEN-1:0]   n_arg_0,
  output logic [XLEN-1:0]   n_arg_1
);

  localparam logic [XLEN-1:0] TOP_BIT = {1'b1, {(XLEN-1){1'b0}}};

  logic take;

  // The full-width compare keeps high divisor bits from aliasing into the 32-bit subtract.
  always_comb begin
    take    = (acc <= {{XLEN{1'b0}}, arg_0});
    n_acc   = acc >> 1;
    n_arg_0 = take ? (arg_0 - acc[XLEN-1:0]) : arg_0;
    n_arg_1 = take ? (arg_1 | (TOP_BIT >> count)) : arg_1;
  end

endmodule

// File: rtl/xc_malu_div_seq.sv
// Iterative 32-bit DIV/DIVU/REM/REMU sequencer: 32 restoring steps, RISC-V sign rules,
// one-cycle registered completion pulse.
module xc_malu_div_seq
  import xc_malu_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            valid,
  input  logic            op_signed,
  input  logic            op_rem,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] result,
  output logic            ready,
  output logic            busy
);

  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  state_t            state;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   arg_0;
  logic [XLEN-1:0]   arg_1;
  logic              neg_q;
  logic              neg_r;
  logic              rem_sel;

  logic [2*XLEN-1:0] n_acc;
  logic [XLEN-1:0]   n_arg_0;
  logic [XLEN-1:0]   n_arg_1;

  xc_malu_div_step u_step (
    .count   (count),
    .acc     (acc),
    .arg_0   (arg_0),
    .arg_1   (arg_1),
    .n_acc   (n_acc),
    .n_arg_0 (n_arg_0),
    .n_arg_1 (n_arg_1)
  );

  // A zero divisor suppresses the quotient sign so the all-ones quotient survives.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      acc     <= '0;
      arg_0   <= '0;
      arg_1   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem_sel <= 1'b0;
      result  <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      count <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid) begin
            arg_0   <= op_signed ? magnitude(rs1) : rs1;
            acc     <= {{XLEN{1'b0}}, (op_signed ? magnitude(rs2) : rs2)} << (XLEN - 1);
            arg_1   <= '0;
            count   <= '0;
            neg_q   <= op_signed & (rs1[XLEN-1] ^ rs2[XLEN-1]) & (rs2 != '0);
            neg_r   <= op_signed & rs1[XLEN-1];
            rem_sel <= op_rem;
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= n_acc;
          arg_0 <= n_arg_0;
          arg_1 <= n_arg_1;
          count <= count + CW'(1);
          if (count == LAST) begin
            result <= rem_sel ? (neg_r ? -n_arg_0 : n_arg_0)
                              : (neg_q ? -n_arg_1 : n_arg_1);
            ready  <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xc_malu_div_seq.sv
// Directed, table-driven bench for xc_malu_div_seq with hand-written flush/reset sequences.
module tb_xc_malu_div_seq;

  logic        clock;
  logic        reset;
  logic        valid;
  logic        op_signed;
  logic        op_rem;
  logic        flush;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] result;
  logic        ready;
  logic        busy;

  int tests_run;
  int tests_failed;

  xc_malu_div_seq dut (
    .clock     (clock),
    .reset     (reset),
    .valid     (valid),
    .op_signed (op_signed),
    .op_rem    (op_rem),
    .flush     (flush),
    .rs1       (rs1),
    .rs2       (rs2),
    .result    (result),
    .ready     (ready),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        op_signed;
    logic        op_rem;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs[15];

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic step_cycle();
    @(posedge clock);
    #1;
  endtask

  // Launches one operation and follows it to the ready pulse, scrambling the operand
  // inputs mid-run; the design is left in its DONE cycle on return.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic sgn, input logic rem,
                                input logic [31:0] prev_result,
                                output logic [31:0] res, output int lat,
                                output logic busy_ok, output logic held_ok);
    int cycles;
    rs1       = a;
    rs2       = b;
    op_signed = sgn;
    op_rem    = rem;
    valid     = 1'b1;
    busy_ok   = 1'b1;
    held_ok   = 1'b1;
    cycles    = 0;
    res       = '0;
    lat       = 0;
    while (cycles <= 40) begin
      step_cycle();
      cycles++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (cycles == 5) begin
        rs1       = $urandom;
        rs2       = $urandom;
        op_signed = ~sgn;
        op_rem    = ~rem;
      end
      if (ready === 1'b1) break;
      if (result !== prev_result) held_ok = 1'b0;
    end
    lat   = cycles;
    res   = result;
    valid = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] last_res;
    int          lat;
    logic        busy_ok;
    logic        held_ok;
    int          pulses;
    int          busy_seen;

    tests_run    = 0;
    tests_failed = 0;

    vecs[0]  = '{32'd100,      32'd7,        1'b0, 1'b0, 32'd14};
    vecs[1]  = '{32'd100,      32'd7,        1'b0, 1'b1, 32'd2};
    vecs[2]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 1'b0, 32'hFFFFFFFD};
    vecs[3]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 1'b1, 32'hFFFFFFFF};
    vecs[4]  = '{32'h12345678, 32'd0,        1'b1, 1'b0, 32'hFFFFFFFF};
    vecs[5]  = '{32'h12345678, 32'd0,        1'b1, 1'b1, 32'h12345678};
    vecs[6]  = '{32'h12345678, 32'd0,        1'b0, 1'b0, 32'hFFFFFFFF};
    vecs[7]  = '{32'h12345678, 32'd0,        1'b0, 1'b1, 32'h12345678};
    vecs[8]  = '{32'hFFFFFF00, 32'd0,        1'b1, 1'b0, 32'hFFFFFFFF};
    vecs[9]  = '{32'hFFFFFF00, 32'd0,        1'b1, 1'b1, 32'hFFFFFF00};
    vecs[10] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000};
    vecs[11] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000};
    vecs[12] = '{32'd7,        32'hFFFFFFFE, 1'b1, 1'b0, 32'hFFFFFFFD};
    vecs[13] = '{32'd7,        32'hFFFFFFFE, 1'b1, 1'b1, 32'd1};
    vecs[14] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000};

    reset     = 1'b1;
    valid     = 1'b0;
    flush     = 1'b0;
    op_signed = 1'b0;
    op_rem    = 1'b0;
    rs1       = '0;
    rs2       = '0;
    step_cycle();
    step_cycle();
    check_output("reset_result", result, 32'h0);
    check_output("reset_ready", {31'b0, ready}, 32'h0);
    check_output("reset_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    step_cycle();

    last_res = 32'h0;
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i].rs1, vecs[i].rs2, vecs[i].op_signed, vecs[i].op_rem,
                     last_res, res, lat, busy_ok, held_ok);
      check_output($sformatf("vec%0d_result", i), res, vecs[i].expected);
      check_output($sformatf("vec%0d_latency", i), lat, 32'd33);
      check_output($sformatf("vec%0d_busy_run", i), {31'b0, busy_ok}, 32'h1);
      check_output($sformatf("vec%0d_result_held", i), {31'b0, held_ok}, 32'h1);
      step_cycle();
      check_output($sformatf("vec%0d_ready_drop", i), {31'b0, ready}, 32'h0);
      check_output($sformatf("vec%0d_busy_drop", i), {31'b0, busy}, 32'h0);
      check_output($sformatf("vec%0d_result_keep", i), result, vecs[i].expected);
      last_res = vecs[i].expected;
    end

    // Flush at cycle 10 of a 100/7 divide: aborts with no ready pulse.
    rs1 = 32'd100; rs2 = 32'd7; op_signed = 1'b0; op_rem = 1'b0; valid = 1'b1;
    step_cycle();
    for (int c = 1; c < 10; c++) step_cycle();
    valid = 1'b0;
    flush = 1'b1;
    step_cycle();
    flush = 1'b0;
    check_output("flush_busy", {31'b0, busy}, 32'h0);
    check_output("flush_ready", {31'b0, ready}, 32'h0);
    pulses = 0;
    busy_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (ready === 1'b1) pulses++;
      if (busy === 1'b1) busy_seen++;
      step_cycle();
    end
    check_output("flush_no_pulse", pulses, 32'd0);
    check_output("flush_stays_idle", busy_seen, 32'd0);
    check_output("flush_result_kept", result, last_res);

    apply_stimulus(32'd9, 32'd3, 1'b0, 1'b0, last_res, res, lat, busy_ok, held_ok);
    check_output("post_flush_result", res, 32'd3);
    check_output("post_flush_latency", lat, 32'd33);
    check_output("post_flush_held", {31'b0, held_ok}, 32'h1);

    // Flush in the DONE cycle: the pulse already showing stays, result is kept.
    flush = 1'b1;
    check_output("done_flush_ready_visible", {31'b0, ready}, 32'h1);
    step_cycle();
    flush = 1'b0;
    check_output("done_flush_ready", {31'b0, ready}, 32'h0);
    check_output("done_flush_busy", {31'b0, busy}, 32'h0);
    check_output("done_flush_result", result, 32'd3);
    step_cycle();

    // Reset at cycle 20 of RUN.
    rs1 = 32'd100; rs2 = 32'd7; op_signed = 1'b0; op_rem = 1'b1; valid = 1'b1;
    step_cycle();
    for (int c = 1; c < 20; c++) step_cycle();
    valid = 1'b0;
    check_output("pre_reset_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
    check_output("midrun_reset_ready", {31'b0, ready}, 32'h0);
    check_output("midrun_reset_busy", {31'b0, busy}, 32'h0);
    check_output("midrun_reset_result", result, 32'h0);

    // valid together with flush in IDLE must not launch.
    valid = 1'b1;
    flush = 1'b1;
    step_cycle();
    valid = 1'b0;
    flush = 1'b0;
    busy_seen = 0;
    pulses = 0;
    for (int c = 0; c < 36; c++) begin
      if (busy === 1'b1) busy_seen++;
      if (ready === 1'b1) pulses++;
      step_cycle();
    end
    check_output("valid_flush_no_busy", busy_seen, 32'd0);
    check_output("valid_flush_no_ready", pulses, 32'd0);

    apply_stimulus(32'd100, 32'd7, 1'b0, 1'b1, 32'h0, res, lat, busy_ok, held_ok);
    check_output("recover_result", res, 32'd2);
    check_output("recover_latency", lat, 32'd33);
    step_cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/xc_malu_div_seq.md
Name: xc_malu_div_seq

Overview:
- Iterative 32-bit divide/remainder sequencer for the MALU.
- Sits directly upstream of the single-iteration divrem step logic:
  - owns the count, divisor accumulator, dividend and quotient registers;
  - advances them one restoring-division step per cycle;
  - applies RISC-V sign and corner-case rules;
  - returns one registered result to the issuing pipeline stage over a valid/ready handshake.

Parameters:
- XLEN, 32: operand and result width; only 32 is supported.
- CW, 6: step counter width.

Ports:
- clock  in  1  design clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- valid  in  1  request; held high by the requester until ready is seen.
- op_signed  in  1  1 = DIV/REM, 0 = DIVU/REMU.
- op_rem  in  1  1 = return remainder, 0 = return quotient.
- flush  in  1  synchronous abort of any in-flight operation.
- rs1  in  32  dividend; sampled only on launch.
- rs2  in  32  divisor; sampled only on launch.
- result  out  32  quotient or remainder; valid only while ready=1.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high in RUN and DONE.

Behaviour:
- Reset (reset=1 at an edge):
  - state goes to IDLE; count, acc, arg_0 and arg_1 clear to 0;
  - result, ready and busy are 0 in the following cycle;
  - reset overrides everything, including mid-RUN.
- States: IDLE, RUN, DONE.
- IDLE:
  - If valid=1 and flush=0, launch:
    - arg_0 = op_signed ? |rs1| : rs1;
    - acc = {32'b0, op_signed ? |rs2| : rs2} << 31;
    - arg_1 = 0; count = 0;
    - latch neg_q = op_signed & (rs1[31]^rs2[31]) & (rs2!=0);
    - latch neg_r = op_signed & rs1[31];
    - latch op_rem;
    - go to RUN.
  - |x| is the 32-bit two's-complement negate when x[31]=1. |0x80000000| = 0x80000000, treated as unsigned.
- RUN, one step per cycle:
  - If acc <= {32'b0, arg_0}: arg_0 -= acc[31:0] and arg_1[31-count] = 1.
  - acc >>= 1; count += 1.
  - The step with count==31 goes to DONE and registers result:
    - op_rem: remainder = neg_r ? -arg_0' : arg_0'.
    - otherwise: quotient = neg_q ? -arg_1' : arg_1'.
- DONE:
  - ready=1 for exactly one cycle, then IDLE.
  - The requester drops valid on the edge where it samples ready, so there is no relaunch.
- Latency: valid first seen in IDLE at cycle 0 → RUN in cycles 1..32 → ready=1 in cycle 33. No early termination.
- result:
  - holds its value after DONE until the next completion or reset;
  - is not cleared by flush.
- Divide by zero:
  - quotient = 0xFFFFFFFF, since the algorithm sets all quotient bits and neg_q is suppressed;
  - remainder = rs1.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- flush=1 at an edge, in any state:
  - next state IDLE, ready=0, count=0;
  - flush and valid together in IDLE: flush wins, no launch;
  - flush in DONE: the ready pulse of that cycle is still visible combinationally; the result register keeps the completed value.
- Inputs rs1, rs2, op_signed and op_rem are ignored outside the launch cycle. Changing them mid-RUN has no effect.
- All arithmetic is unsigned on magnitudes. The subtract comparison is 64-bit to avoid overflow of the shifted divisor.

Decomposition:
- Package xc_malu_pkg:
  - XLEN, CW;
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - a function returning the two's-complement magnitude.
- Sub-module xc_malu_div_step: purely combinational single iteration.
  - in: count, acc, arg_0, arg_1;
  - out: n_acc, n_arg_0, n_arg_1.
  - The sequencer instantiates it once and registers its outputs.

Test Plan:
- Unsigned: rs1=100, rs2=7, op_signed=0. op_rem=0 → result=14; op_rem=1 → result=2. In both cases ready in cycle 33 after launch, busy high cycles 1..33.
- Signed: rs1=0xFFFFFFF9 (-7), rs2=2, op_signed=1. Quotient → 0xFFFFFFFD (-3); remainder → 0xFFFFFFFF (-1).
- Divide by zero:
  - rs1=0x12345678, rs2=0, signed and unsigned. Quotient → 0xFFFFFFFF; remainder → 0x12345678.
  - rs1=0xFFFFFF00, rs2=0, signed. Quotient → 0xFFFFFFFF; remainder → 0xFFFFFF00.
- Overflow: rs1=0x80000000, rs2=0xFFFFFFFF, signed. Quotient → 0x80000000; remainder → 0.
- Flush: launch 100/7, assert flush at cycle 10 → IDLE next cycle, no ready pulse. Then launch 9/3 → result=3 after 33 cycles, previous result register unchanged in between.
- Reset mid-op: reset=1 at cycle 20 of RUN → next cycle ready=0, busy=0, result=0. valid+flush together in IDLE → no launch, busy stays 0.
